// File: rtl/interval_merger_if.sv
// Stream bundle for interval_merger: sorted range input, merged range output,
// and the coverage total. The slave side is the merger; the master side feeds and drains it.
interface interval_merger_if #(
  parameter int BIT_WIDTH   = 32,
  parameter int COUNT_WIDTH = 64
);
  logic                   in_valid;
  logic [BIT_WIDTH-1:0]   in_start;
  logic [BIT_WIDTH-1:0]   in_end;
  logic                   in_last;
  logic                   in_ready;
  logic                   out_valid;
  logic [BIT_WIDTH-1:0]   out_start;
  logic [BIT_WIDTH-1:0]   out_end;
  logic                   out_last;
  logic                   out_ready;
  logic                   total_valid;
  logic [COUNT_WIDTH-1:0] total;

  modport slave (
    input  in_valid, in_start, in_end, in_last, out_ready,
    output in_ready, out_valid, out_start, out_end, out_last, total_valid, total
  );

  modport master (
    output in_valid, in_start, in_end, in_last, out_ready,
    input  in_ready, out_valid, out_start, out_end, out_last, total_valid, total
  );
endinterface

// File: rtl/interval_merger.sv
// Coalesces a start-sorted stream of inclusive ranges into disjoint merged ranges
// and accumulates how many integers the merged ranges cover.
module interval_merger #(
  parameter int BIT_WIDTH   = 32,
  parameter int COUNT_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  interval_merger_if.slave  bus
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t               state;
  logic                 cur_valid;
  logic [BIT_WIDTH-1:0] cur_start;
  logic [BIT_WIDTH-1:0] cur_end;

  logic out_free;
  logic accept;
  logic well_formed;
  logic eos;
  logic can_merge;

  function automatic logic [COUNT_WIDTH-1:0] range_len(
    input logic [BIT_WIDTH-1:0] s,
    input logic [BIT_WIDTH-1:0] e
  );
    return COUNT_WIDTH'(e) - COUNT_WIDTH'(s) + COUNT_WIDTH'(1);
  endfunction

  assign out_free    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = (state == RUN) && !rst && out_free;
  assign accept      = bus.in_valid && bus.in_ready;
  assign well_formed = bus.in_end >= bus.in_start;
  assign eos         = bus.in_last && !bus.in_valid;
  // One extra bit so a held end of all-ones absorbs every later start.
  assign can_merge   = {1'b0, bus.in_start} <= ({1'b0, cur_end} + (BIT_WIDTH+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      cur_valid       <= 1'b0;
      cur_start       <= '0;
      cur_end         <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_start   <= '0;
      bus.out_end     <= '0;
      bus.out_last    <= 1'b0;
      bus.total       <= '0;
      bus.total_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking semantics let this default clear be overridden below
      // by a reload in the same cycle, so the output register refills without a bubble.
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

      case (state)
        RUN: begin
          if (accept) begin
            if (well_formed) begin
              if (!cur_valid) begin
                cur_valid <= 1'b1;
                cur_start <= bus.in_start;
                cur_end   <= bus.in_end;
              end else if (can_merge) begin
                if (bus.in_end > cur_end) cur_end <= bus.in_end;
              end else begin
                bus.out_valid <= 1'b1;
                bus.out_start <= cur_start;
                bus.out_end   <= cur_end;
                bus.out_last  <= 1'b0;
                bus.total     <= bus.total + range_len(cur_start, cur_end);
                cur_start     <= bus.in_start;
                cur_end       <= bus.in_end;
              end
            end
          end else if (eos) begin
            state <= FLUSH;
          end
        end

        FLUSH: begin
          if (cur_valid) begin
            if (out_free) begin
              bus.out_valid <= 1'b1;
              bus.out_start <= cur_start;
              bus.out_end   <= cur_end;
              bus.out_last  <= 1'b1;
              bus.total     <= bus.total + range_len(cur_start, cur_end);
              cur_valid     <= 1'b0;
            end
          end else if (out_free) begin
            // Held range gone and the last beat (if any) is leaving now.
            state           <= DONE;
            bus.total_valid <= 1'b1;
          end
        end

        DONE: begin
          bus.total_valid <= 1'b1;
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_interval_merger.sv
// Directed bench for interval_merger at BIT_WIDTH=8: stimulus pushes expected merged
// ranges into a queue, a monitor pops and compares on every output handshake.
module tb_interval_merger;

  localparam int BW = 8;
  localparam int CW = 64;

  typedef struct packed {
    logic [BW-1:0] s;
    logic [BW-1:0] e;
    logic          l;
  } beat_t;

  logic clk;
  logic rst;
  interval_merger_if #(.BIT_WIDTH(BW), .COUNT_WIDTH(CW)) bus ();

  interval_merger #(.BIT_WIDTH(BW), .COUNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];

  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  logic [1:0] cyc     = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Downstream ready: always 1, or a repeating 1-0-0-1 pattern under backpressure.
  always @(posedge clk) cyc <= cyc + 2'd1;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? bp_pat[cyc] : 1'b1;
    end
  end

  // Monitor: scoreboard pops, output stability under stall, in_ready under stall.
  initial begin
    logic          prev_stall;
    logic [BW-1:0] held_s, held_e;
    logic          held_l;
    beat_t         b;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(bus.out_valid), 64'd1);
          check("stall_start", 64'(bus.out_start), 64'(held_s));
          check("stall_end",   64'(bus.out_end),   64'(held_e));
          check("stall_last",  64'(bus.out_last),  64'(held_l));
        end
        if (bus.out_valid && !bus.out_ready)
          check("in_ready_stall", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(bus.out_start), 64'hFFFF_FFFF);
          end else begin
            b = exp_q.pop_front();
            check("out_start", 64'(bus.out_start), 64'(b.s));
            check("out_end",   64'(bus.out_end),   64'(b.e));
            check("out_last",  64'(bus.out_last),  64'(b.l));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        held_s = bus.out_start;
        held_e = bus.out_end;
        held_l = bus.out_last;
      end
    end
  end

  task automatic expect_beat(input int s, input int e, input logic l);
    beat_t b;
    b.s = BW'(s);
    b.e = BW'(e);
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_start = '0;
    bus.in_end   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",    64'(bus.in_ready),    64'd0);
    check("rst_out_valid",   64'(bus.out_valid),   64'd0);
    check("rst_out_last",    64'(bus.out_last),    64'd0);
    check("rst_total",       bus.total,            64'd0);
    check("rst_total_valid", 64'(bus.total_valid), 64'd0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic send(input int s, input int e);
    int k;
    bus.in_valid = 1'b1;
    bus.in_start = BW'(s);
    bus.in_end   = BW'(e);
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Ends the stream and waits for the final total; returns edges taken.
  task automatic end_stream(input string name, input logic [63:0] exp_total, output int edges);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b1;
    edges = 0;
    while (!bus.total_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({name, "_total_valid"}, 64'(bus.total_valid), 64'd1);
    check({name, "_total"},       bus.total,            exp_total);
    check({name, "_drained"},     64'(exp_q.size()),    64'd0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_sticky"}, 64'(bus.total_valid), 64'd1);
    bus.in_last = 1'b0;
  endtask

  task automatic example_merge(input string name);
    int edges;
    expect_beat(3, 5, 1'b0);
    expect_beat(10, 20, 1'b1);
    send(3, 5);
    send(10, 14);
    send(12, 18);
    send(16, 20);
    end_stream(name, 64'd14, edges);
  endtask

  initial begin
    int edges;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_start = '0;
    bus.in_end   = '0;
    do_reset();

    example_merge("example");
    do_reset();

    expect_beat(1, 10, 1'b1);
    send(1, 4);
    send(5, 5);
    send(6, 10);
    send(7, 8);
    end_stream("adjacent", 64'd10, edges);
    do_reset();

    end_stream("empty", 64'd0, edges);
    check("empty_latency", 64'(edges), 64'd2);
    do_reset();

    expect_beat(4, 4, 1'b1);
    send(9, 2);
    send(4, 4);
    end_stream("malformed", 64'd1, edges);
    do_reset();

    expect_beat(0, 255, 1'b1);
    send(0, 255);
    end_stream("full_range", 64'd256, edges);
    do_reset();

    expect_beat(0, 255, 1'b1);
    send(0, 254);
    send(255, 255);
    end_stream("top_adjacent", 64'd256, edges);
    do_reset();

    expect_beat(0, 255, 1'b1);
    send(0, 255);
    send(3, 4);
    end_stream("all_ones_absorbs", 64'd256, edges);
    do_reset();

    bp_mode = 1'b1;
    example_merge("backpressure");
    bp_mode = 1'b0;
    do_reset();

    send(3, 5);
    send(10, 14);
    do_reset();
    example_merge("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
